// File: rtl/scan_addr_gen_pkg.sv
// scan_addr_gen_pkg
// Shared constants for the scan address generator: FSM state encoding and
// default parameter values. The states are plain localparams so the encoding
// stays fixed and readable in waveforms of older tools.
package scan_addr_gen_pkg;

  localparam int N_DEF       = 4;
  localparam int DWELL_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

endpackage

// File: rtl/scan_addr_gen_dwell_timer.sv
// dwell_timer
// Loadable down-counter that sets how many cycles each address is held.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset (count -> 0)
//   load     - load load_val (takes priority over dec)
//   load_val - value to load
//   dec      - decrement by one; low freezes the count (used for hold)
//   count    - current count
//   zero     - count == 0
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic [DWELL_W-1:0] count,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_r;

  // Down-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= DWELL_W'(0);
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec) begin
      cnt_r <= cnt_r - DWELL_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;
  assign zero  = (cnt_r == DWELL_W'(0));

endmodule

// File: rtl/scan_addr_gen.sv
// scan_addr_gen
// Sweeps addresses first..last (ascending, modulo 2^N) for an N-to-2^N
// decoder, holding each address dwell+1 cycles, in single-pass or
// continuous mode. All outputs are registered.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a sweep (sampled only when idle)
//   stop                - abort a running sweep (highest priority)
//   hold                - freeze the sweep while high
//   mode                - 0 single pass, 1 continuous (latched at start)
//   first, last, dwell  - sweep configuration (latched at start)
//   A, en               - decoder address and enable
//   step                - pulse on the first cycle of each new address
//   busy                - sweep in progress (RUN or HOLD)
//   done                - pulse after a single pass completes
module scan_addr_gen
  import scan_addr_gen_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               mode,
  input  logic [N-1:0]       first,
  input  logic [N-1:0]       last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       A,
  output logic               en,
  output logic               step,
  output logic               busy,
  output logic               done
);

  logic [1:0]         state_r;
  logic [N-1:0]       first_r;
  logic [N-1:0]       last_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               mode_r;
  logic [N-1:0]       a_r;
  logic               en_r;
  logic               step_r;
  logic               busy_r;
  logic               done_r;

  logic               sweeping_s;
  logic               active_s;
  logic               final_s;
  logic               tmr_load_s;
  logic [DWELL_W-1:0] tmr_val_s;
  logic               tmr_dec_s;
  logic [DWELL_W-1:0] tmr_count_s;
  logic               tmr_zero_s;

  // Timer control: load on start and on every advance; count down only when
  // the sweep is running and neither stopped nor held.
  always_comb begin
    sweeping_s = (state_r == ST_RUN) || (state_r == ST_HOLD);
    active_s   = sweeping_s && !stop && !hold;
    final_s    = (a_r == last_r) && !mode_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = dwell_r;
    tmr_dec_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      tmr_load_s = start;
      tmr_val_s  = dwell;
    end else if (active_s) begin
      tmr_load_s = tmr_zero_s && !final_s;
      tmr_dec_s  = !tmr_zero_s;
    end else begin
      tmr_load_s = 1'b0;
      tmr_dec_s  = 1'b0;
    end
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .count    (tmr_count_s),
    .zero     (tmr_zero_s)
  );

  // FSM, shadow registers, address incrementer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      first_r <= N'(0);
      last_r  <= N'(0);
      dwell_r <= DWELL_W'(0);
      mode_r  <= 1'b0;
      a_r     <= N'(0);
      en_r    <= 1'b0;
      step_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          step_r <= 1'b0;
          done_r <= 1'b0;
          if (start) begin
            first_r <= first;
            last_r  <= last;
            dwell_r <= dwell;
            mode_r  <= mode;
            a_r     <= first;
            en_r    <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN, ST_HOLD: begin
          done_r <= 1'b0;
          if (stop) begin
            // A keeps its last value on abort.
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            step_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (hold) begin
            step_r  <= 1'b0;
            state_r <= ST_HOLD;
          end else if (tmr_zero_s) begin
            // Leaving HOLD behaves exactly like a RUN cycle, so no cycle is lost.
            if (a_r != last_r) begin
              a_r     <= a_r + N'(1);
              step_r  <= 1'b1;
              state_r <= ST_RUN;
            end else if (mode_r) begin
              a_r     <= first_r;
              step_r  <= 1'b1;
              state_r <= ST_RUN;
            end else begin
              en_r    <= 1'b0;
              busy_r  <= 1'b0;
              step_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            step_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          en_r    <= 1'b0;
          busy_r  <= 1'b0;
          step_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign A    = a_r;
  assign en   = en_r;
  assign step = step_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed self-checking bench for scan_addr_gen (N=4, DWELL_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_scan_addr_gen;

  logic       clk = 1'b0;
  logic       rst, start, stop, hold, mode;
  logic [3:0] first, last;
  logic [7:0] dwell;
  logic [3:0] A;
  logic       en, step, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_addr_gen #(.N(4), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .hold  (hold),
    .mode  (mode),
    .first (first),
    .last  (last),
    .dwell (dwell),
    .A     (A),
    .en    (en),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single pass: starts the sweep and leaves the bench in the done cycle.
  task automatic run_single(input logic [3:0] f, input logic [3:0] l, input int d);
    int k;
    int n;
    logic [3:0] ea;
    first = f; last = l; dwell = d[7:0]; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    k = int'(4'(l - f)) + 1;
    n = k * (d + 1);
    for (int j = 0; j < n; j++) begin
      ea = 4'(int'(f) + j / (d + 1));
      chk("sp_A", {12'h000, A}, {12'h000, ea});
      chk("sp_en", {15'h0000, en}, 16'h0001);
      chk("sp_busy", {15'h0000, busy}, 16'h0001);
      chk("sp_step", {15'h0000, step}, (j != 0 && (j % (d + 1)) == 0) ? 16'h0001 : 16'h0000);
      chk("sp_done_low", {15'h0000, done}, 16'h0000);
      tick();
    end
    chk("sp_done", {15'h0000, done}, 16'h0001);
    chk("sp_en_off", {15'h0000, en}, 16'h0000);
    chk("sp_busy_off", {15'h0000, busy}, 16'h0000);
    chk("sp_A_last", {12'h000, A}, {12'h000, l});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
    first = 4'h0; last = 4'h0; dwell = 8'h00;
    tick();
    tick();
    chk("rst_A", {12'h000, A}, 16'h0000);
    chk("rst_en", {15'h0000, en}, 16'h0000);
    chk("rst_busy", {15'h0000, busy}, 16'h0000);
    chk("rst_step", {15'h0000, step}, 16'h0000);
    chk("rst_done", {15'h0000, done}, 16'h0000);
    rst = 1'b0;
    tick();

    // 1: full 0..15, one address per cycle
    run_single(4'd0, 4'd15, 0);
    tick();
    chk("t1_done_pulse", {15'h0000, done}, 16'h0000);
    chk("t1_busy", {15'h0000, busy}, 16'h0000);

    // 2: 3..5, dwell 2
    run_single(4'd3, 4'd5, 2);
    tick();
    chk("t2_done_pulse", {15'h0000, done}, 16'h0000);

    // 3: wrap 14..1, then a new start in the done cycle (K=1)
    run_single(4'd14, 4'd1, 0);
    run_single(4'd5, 4'd5, 0);
    tick();

    // 4: continuous 2..4 with stop while A=3 (second lap)
    first = 4'd2; last = 4'd4; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_A0", {12'h000, A}, 16'h0002);
    tick();
    chk("t4_A1", {12'h000, A}, 16'h0003);
    tick();
    chk("t4_A2", {12'h000, A}, 16'h0004);
    tick();
    chk("t4_A3", {12'h000, A}, 16'h0002);
    chk("t4_step_wrap", {15'h0000, step}, 16'h0001);
    chk("t4_done_wrap", {15'h0000, done}, 16'h0000);
    tick();
    chk("t4_A4", {12'h000, A}, 16'h0003);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop_en", {15'h0000, en}, 16'h0000);
    chk("t4_stop_busy", {15'h0000, busy}, 16'h0000);
    chk("t4_stop_done", {15'h0000, done}, 16'h0000);
    chk("t4_stop_A", {12'h000, A}, 16'h0003);
    tick();
    chk("t4_after_done", {15'h0000, done}, 16'h0000);
    chk("t4_after_en", {15'h0000, en}, 16'h0000);

    // 5: 6..9 dwell 3, hold 5 cycles from the 2nd cycle of A=7
    first = 4'd6; last = 4'd9; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("t5_A6", {12'h000, A}, 16'h0006);
      tick();
    end
    chk("t5_A7_first", {12'h000, A}, 16'h0007);
    chk("t5_step7", {15'h0000, step}, 16'h0001);
    tick();
    hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      chk("t5_hold_A", {12'h000, A}, 16'h0007);
      chk("t5_hold_en", {15'h0000, en}, 16'h0001);
      chk("t5_hold_busy", {15'h0000, busy}, 16'h0001);
      tick();
    end
    hold = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("t5_resume_A", {12'h000, A}, 16'h0007);
      chk("t5_resume_step", {15'h0000, step}, 16'h0000);
      tick();
    end
    chk("t5_A8", {12'h000, A}, 16'h0008);
    chk("t5_step8", {15'h0000, step}, 16'h0001);
    for (int j = 0; j < 8; j++) begin
      chk("t5_tail_A", {12'h000, A}, (j < 4) ? 16'h0008 : 16'h0009);
      chk("t5_tail_en", {15'h0000, en}, 16'h0001);
      tick();
    end
    chk("t5_done", {15'h0000, done}, 16'h0001);
    chk("t5_en_off", {15'h0000, en}, 16'h0000);
    tick();

    // 6: start mid-run ignored, then reset mid-run
    first = 4'd0; last = 4'd3; dwell = 8'd1; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_A0a", {12'h000, A}, 16'h0000);
    first = 4'd10; last = 4'd12; dwell = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_A0b", {12'h000, A}, 16'h0000);
    chk("t6_step0b", {15'h0000, step}, 16'h0000);
    tick();
    chk("t6_A1a", {12'h000, A}, 16'h0001);
    chk("t6_step1", {15'h0000, step}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_A", {12'h000, A}, 16'h0000);
    chk("t6_rst_en", {15'h0000, en}, 16'h0000);
    chk("t6_rst_busy", {15'h0000, busy}, 16'h0000);
    chk("t6_rst_step", {15'h0000, step}, 16'h0000);
    chk("t6_rst_done", {15'h0000, done}, 16'h0000);
    tick();
    chk("t6_post_done", {15'h0000, done}, 16'h0000);
    chk("t6_post_en", {15'h0000, en}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
Sequential address generator that sits directly upstream of the parameterized N-to-M decoder (dec_N_M, ports A/Y). It sweeps a programmable address range, holding each address a programmable number of cycles, in single-pass or continuous mode. It drives the decoder's A input plus an enable/valid qualifier. Typical use is display-digit scanning and one-hot row strobing.

Parameters:
N, 4, address width; must match dec_N_M N (decoder M = 2^N).
DWELL_W, 8, width of the dwell (cycles-per-address) field.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  start request; sampled only in IDLE.
stop  in  1  abort request; honoured in RUN/HOLD.
hold  in  1  freeze the sweep while high (RUN/HOLD only).
mode  in  1  0 = single pass, 1 = continuous; latched at start.
first  in  N  first address of the sweep; latched at start.
last  in  N  last address of the sweep; latched at start.
dwell  in  DWELL_W  each address is held dwell+1 cycles; latched at start.
A  out  N  address to the decoder.
en  out  1  A valid / decoder enable.
step  out  1  one-cycle pulse in the first cycle of each new address after the first one.
busy  out  1  high in RUN and HOLD.
done  out  1  one-cycle pulse at the end of a single pass.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: A=0, en=0, step=0, busy=0, done=0, state=IDLE, dwell counter=0. Reset mid-run takes effect at the next edge and produces no done.
- States:
  - IDLE: start=1 -> RUN. Latch first_r/last_r/dwell_r/mode_r. Set A=first, en=1, busy=1, counter=dwell.
  - RUN: hold=1 -> HOLD (counter and A frozen, en stays 1).
  - HOLD: hold=0 -> RUN, resuming with the remaining count. No cycle is lost or gained beyond the hold duration.
- Priority in RUN/HOLD: stop > hold > advance.
  - stop=1 -> IDLE next cycle: en=0, busy=0, done=0. A keeps its last value.
- Advance, in RUN when counter==0:
  - A!=last_r: A <= A+1 mod 2^N, counter <= dwell_r, step=1.
  - A==last_r and mode_r=1: A <= first_r, counter <= dwell_r, step=1.
  - A==last_r and mode_r=0: -> IDLE, en=0, busy=0, done=1 for one cycle. A holds last_r.
- Otherwise (counter != 0): counter decrements.
- Wrap: addresses ascend modulo 2^N, so first>last sweeps through all-ones to 0.
  - Addresses per pass K = ((last-first) mod 2^N) + 1. first==last gives K=1.
- Single-pass timing (no hold): start sampled at edge t0.
  - en=1 in cycles t0+1 .. t0+K*(dwell+1).
  - done=1 in cycle t0+K*(dwell+1)+1, with en=0.
  - step pulses = K-1.
- start is ignored while busy.
- Live changes to first/last/dwell/mode during a run have no effect.
- start and done may coincide: start in the done cycle (already IDLE) begins a new pass next cycle.
- dwell=0: one address per cycle.

Decomposition:
- Shared package: state encoding ST_IDLE=2'b00, ST_RUN=2'b01, ST_HOLD=2'b10; default N and DWELL_W constants.
- One sub-module, dwell_timer: loadable DWELL_W-bit down-counter with load, enable (freeze on hold) and zero-flag outputs.
- The top level holds the FSM, shadow registers and address incrementer.
- Benches instantiate scan_addr_gen driving dec_N_M #(4,16).

Test Plan:
1. rst, then start with first=0, last=15, dwell=0, mode=0 -> A=0..15 one per cycle; en high 16 cycles; decoder Y walks 16'h0001..16'h8000; step 15 pulses; done one cycle after en falls; busy low afterwards.
2. first=3, last=5, dwell=2, mode=0 -> A=3,3,3,4,4,4,5,5,5; en 9 cycles; step 2 pulses; done at t0+10.
3. Wrap: first=14, last=1, dwell=0 -> A=14,15,0,1; done after 4 en cycles.
4. Continuous: first=2, last=4, dwell=0, mode=1 -> 2,3,4,2,3,4...; stop asserted while A=3 -> next cycle en=0, busy=0, done never asserted.
5. dwell=3, hold held 5 cycles during the 2nd cycle of A=7 -> A stays 7 for 4+5 cycles total, then advances to 8; en stays 1 throughout.
6. start pulsed mid-run -> ignored, sequence unchanged. rst asserted mid-run -> next cycle A=0, en=0, busy=0, step=0, done=0.
